// File: rtl/sign_extend_stream.sv
// Streaming sign/zero extender with a registered 2-entry skid buffer.
// Ports:
//   clk, areset_n            clock, async active-low reset
//   in_valid/in_ready        input handshake (in_ready registered)
//   in_data/in_len/in_signed raw field, effective length, extend mode
//   out_valid/out_ready      output handshake
//   out_data/out_err         extended value, illegal-length flag
//   err_sticky/beat_cnt/clr  status and synchronous clear
module sign_extend_stream #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16,
    localparam int LEN_W = $clog2(IN_W + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] beat_cnt,
    input  logic             clr
);

    logic             len_ok;
    logic [LEN_W-1:0] eff_len;
    logic             sign_bit;
    logic [OUT_W-1:0] pad;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    // Illegal lengths fall back to the full field width.
    always_comb begin
        len_ok   = (in_len != '0) && (int'(in_len) <= IN_W);
        eff_len  = len_ok ? in_len : LEN_W'(IN_W);
        pad      = OUT_W'(in_data);
        sign_bit = 1'b0;
        ext_data = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_signed && (i == int'(eff_len) - 1)) begin
                sign_bit = in_data[i];
            end
        end
        for (int i = 0; i < OUT_W; i++) begin
            ext_data[i] = (i < int'(eff_len)) ? pad[i] : sign_bit;
        end
        ext_err = !len_ok;
    end

    logic [OUT_W-1:0] skid_data;
    logic             skid_err;
    logic             skid_full;

    logic             acc;
    logic             xfer;

    logic [OUT_W-1:0] main_data_nxt;
    logic             main_err_nxt;
    logic             out_valid_nxt;
    logic [OUT_W-1:0] skid_data_nxt;
    logic             skid_err_nxt;
    logic             skid_full_nxt;
    logic             in_ready_nxt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic             err_sticky_nxt;

    assign acc  = in_valid && in_ready;
    assign xfer = out_valid && out_ready;

    always_comb begin
        main_data_nxt  = out_data;
        main_err_nxt   = out_err;
        out_valid_nxt  = out_valid;
        skid_data_nxt  = skid_data;
        skid_err_nxt   = skid_err;
        skid_full_nxt  = skid_full;
        beat_cnt_nxt   = beat_cnt;
        err_sticky_nxt = err_sticky;

        if (!out_valid || xfer) begin
            // Skid holds the oldest beat, so it drains first.
            if (skid_full) begin
                main_data_nxt = skid_data;
                main_err_nxt  = skid_err;
                out_valid_nxt = 1'b1;
                skid_full_nxt = 1'b0;
            end else if (acc) begin
                main_data_nxt = ext_data;
                main_err_nxt  = ext_err;
                out_valid_nxt = 1'b1;
            end else begin
                out_valid_nxt = 1'b0;
            end
        end else if (acc) begin
            skid_data_nxt = ext_data;
            skid_err_nxt  = ext_err;
            skid_full_nxt = 1'b1;
        end

        in_ready_nxt = !skid_full_nxt;

        if (clr) begin
            beat_cnt_nxt   = '0;
            err_sticky_nxt = 1'b0;
        end else if (acc) begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
            if (ext_err) begin
                err_sticky_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out_data   <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            skid_full  <= 1'b0;
            in_ready   <= 1'b1;
            beat_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            out_data   <= main_data_nxt;
            out_err    <= main_err_nxt;
            out_valid  <= out_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_err   <= skid_err_nxt;
            skid_full  <= skid_full_nxt;
            in_ready   <= in_ready_nxt;
            beat_cnt   <= beat_cnt_nxt;
            err_sticky <= err_sticky_nxt;
        end
    end

endmodule

// File: tb/tb_sign_extend_stream.sv
// Self-checking bench for sign_extend_stream (IN_W=8, OUT_W=32, CNT_W=4).
// Reference: arithmetic extension model plus an occupancy-based FIFO queue.
module tb_sign_extend_stream;

    logic        clk;
    logic        areset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  in_len;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        err_sticky;
    logic [3:0]  beat_cnt;
    logic        clr;

    sign_extend_stream #(.IN_W(8), .OUT_W(32), .CNT_W(4)) dut (
        .clk(clk), .areset_n(areset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .err_sticky(err_sticky), .beat_cnt(beat_cnt), .clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        q[$];
    logic [31:0] popped[$];
    logic [3:0]  cnt_m;
    logic        err_m;
    int          errors;
    int          checks;

    function automatic exp_t ref_ext(logic [7:0] d, logic [3:0] len, logic sg);
        exp_t   r;
        int     l;
        longint v;
        bit     ok;
        ok = (len >= 4'd1) && (len <= 4'd8);
        l = ok ? int'(len) : 8;
        v = longint'(d) & ((longint'(1) << l) - 1);
        if (sg && v >= (longint'(1) << (l - 1))) v = v - (longint'(1) << l);
        r.d = v[31:0];
        r.e = !ok;
        return r;
    endfunction

    // Advances one clock while tracking what the block should hold.
    task automatic tick(output bit acc);
        exp_t b;
        bit   xf;
        acc = in_valid && areset_n && (q.size() < 2);
        xf  = out_ready && (q.size() > 0);
        b   = ref_ext(in_data, in_len, in_signed);
        if (xf) popped.push_back(q.pop_front().d);
        if (acc) q.push_back(b);
        if (clr) begin
            cnt_m = 4'd0;
            err_m = 1'b0;
        end else if (acc) begin
            cnt_m = cnt_m + 4'd1;
            if (b.e) err_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 32'h0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data out_data=%h out_err=%b exp 0/0", out_data, out_err);
        end
        checks++;
        if (beat_cnt !== 4'd0 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_status cnt=%0d sticky=%b exp 0/0", beat_cnt, err_sticky);
        end
        areset_n = 1'b1;
    endtask

    task automatic test_full_len();
        bit a;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_len    = 4'd8;
        in_signed = 1'b1;
        in_data   = 8'hFD;
        tick(a);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFD || out_err !== 1'b0) begin
            errors++;
            $display("FAIL full_neg v=%b data=%h err=%b exp 1/fffffffd/0", out_valid, out_data, out_err);
        end
        in_data = 8'h05;
        tick(a);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000005 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL full_pos v=%b data=%h err=%b exp 1/00000005/0", out_valid, out_data, out_err);
        end
        in_valid = 1'b0;
        tick(a);
    endtask

    task automatic test_short_len();
        bit a;
        in_valid  = 1'b1;
        in_len    = 4'd4;
        in_data   = 8'hAD;
        in_signed = 1'b1;
        tick(a);
        checks++;
        if (out_data !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL len4_signed data=%h exp fffffffd", out_data);
        end
        in_signed = 1'b0;
        tick(a);
        checks++;
        if (out_data !== 32'h0000000D) begin
            errors++;
            $display("FAIL len4_unsigned data=%h exp 0000000d", out_data);
        end
        in_valid = 1'b0;
        tick(a);
    endtask

    task automatic test_illegal_len();
        bit a;
        in_valid  = 1'b1;
        in_signed = 1'b1;
        in_len    = 4'd0;
        in_data   = 8'h9A;
        tick(a);
        checks++;
        if (out_data !== 32'hFFFFFF9A || out_err !== 1'b1 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL len0 data=%h err=%b sticky=%b exp ffffff9a/1/1", out_data, out_err, err_sticky);
        end
        in_len  = 4'd9;
        in_data = 8'h35;
        tick(a);
        checks++;
        if (out_data !== 32'h00000035 || out_err !== 1'b1 || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL len9 data=%h err=%b sticky=%b exp 00000035/1/1", out_data, out_err, err_sticky);
        end
        in_valid = 1'b0;
        clr      = 1'b1;
        tick(a);
        clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr sticky=%b cnt=%0d exp 0/0", err_sticky, beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit          a;
        int          idx;
        int          cyc;
        logic        stalled;
        logic [31:0] held;
        popped.delete();
        idx       = 0;
        cyc       = 0;
        stalled   = 1'b0;
        held      = '0;
        in_len    = 4'd8;
        in_signed = 1'b0;
        while ((idx < 10 || q.size() > 0) && cyc < 40) begin
            in_valid  = (idx < 10);
            in_data   = 8'(idx);
            out_ready = !(cyc >= 4 && cyc < 7);
            if (stalled) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL stall_stable data=%h exp %h", out_data, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick(a);
            if (a) idx++;
            cyc++;
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL bp_hs cyc=%0d in_ready=%b out_valid=%b occ=%0d", cyc, in_ready, out_valid, q.size());
            end
        end
        checks++;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL bp_timeout accepted=%0d exp 10", idx);
        end
        checks++;
        if (popped.size() != 10) begin
            errors++;
            $display("FAIL bp_count got=%0d exp 10", popped.size());
        end
        for (int i = 0; i < popped.size() && i < 10; i++) begin
            checks++;
            if (popped[i] !== 32'(i)) begin
                errors++;
                $display("FAIL bp_order idx=%0d got=%h exp %h", i, popped[i], 32'(i));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_wrap();
        bit a;
        int n;
        int cyc;
        clr = 1'b1;
        tick(a);
        clr       = 1'b0;
        n         = 0;
        cyc       = 0;
        out_ready = 1'b1;
        in_len    = 4'd3;
        in_signed = 1'b1;
        while (n < 17 && cyc < 60) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick(a);
            if (a) n++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (beat_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap cnt=%0d exp 1 (accepted %0d)", beat_cnt, n);
        end
        repeat (3) tick(a);
    endtask

    task automatic test_random();
        bit a;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            in_len    = 4'($urandom_range(0, 15));
            in_signed = 1'($urandom);
            clr       = ($urandom_range(0, 40) == 0);
            tick(a);
            checks++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rnd_hs c=%0d in_ready=%b out_valid=%b occ=%0d", c, in_ready, out_valid, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (out_data !== q[0].d || out_err !== q[0].e) begin
                    errors++;
                    $display("FAIL rnd_data c=%0d data=%h err=%b exp %h/%b", c, out_data, out_err, q[0].d, q[0].e);
                end
            end
            checks++;
            if (beat_cnt !== cnt_m || err_sticky !== err_m) begin
                errors++;
                $display("FAIL rnd_status c=%0d cnt=%0d sticky=%b exp %0d/%b", c, beat_cnt, err_sticky, cnt_m, err_m);
            end
        end
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick(a);
    endtask

    task automatic test_reset_midstream();
        bit a;
        int cyc;
        cyc       = 0;
        out_ready = 1'b0;
        in_len    = 4'd8;
        in_signed = 1'b1;
        while (q.size() < 2 && cyc < 10) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick(a);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_fill occ=%0d in_ready=%b exp 2/0", q.size(), in_ready);
        end
        #2;
        areset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset v=%b rdy=%b cnt=%0d exp 0/1/0", out_valid, in_ready, beat_cnt);
        end
        q.delete();
        cnt_m = 4'd0;
        err_m = 1'b0;
        @(negedge clk);
        areset_n  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h80;
        tick(a);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFF80 || beat_cnt !== 4'd1) begin
            errors++;
            $display("FAIL post_reset v=%b data=%h cnt=%0d exp 1/ffffff80/1", out_valid, out_data, beat_cnt);
        end
        tick(a);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cnt_m     = 4'd0;
        err_m     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = 4'd8;
        in_signed = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        test_reset();
        test_full_len();
        test_short_len();
        test_illegal_len();
        test_backpressure();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
